dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: grants one of three requesters (vga, ldr, cpu) access to an
// SDRAM controller, one transaction at a time. vga has fixed top priority;
// ldr and cpu share round-robin. Every output is registered.
module dram_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic              vga_req,
  input  logic              vga_we,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic [DATA_W-1:0] vga_wdata,
  output logic              vga_done,
  output logic              vga_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_done,
  output logic              ldr_err,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              dram_start,
  output logic              dram_write_en,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              dram_burst_en,
  input  logic              dram_data_ready,
  input  logic [DATA_W-1:0] dram_data_out,
  output logic [1:0]        owner
);

  // Wait counter is at least 10 bits and always wide enough to hold TIMEOUT.
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > 10) ? CNT_RAW : 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VGA  = 2'd1;
  localparam logic [1:0] OWN_LDR  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One-hot {cpu, ldr, vga} select for the done/err pulses of an owner code.
  function automatic logic [2:0] owner_mask(input logic [1:0] own);
    logic [2:0] m;
    case (own)
      OWN_VGA: m = 3'b001;
      OWN_LDR: m = 3'b010;
      OWN_CPU: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              rr_q, rr_d;          // 1: cpu granted last, 0: ldr granted last
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [2:0]        done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic              start_q, start_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              burst_q, burst_d;

  logic [1:0]        sel_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Pick the requester that would win if arbitration happened this cycle.
  always_comb begin
    sel_s = OWN_NONE;
    if (vga_req) begin
      sel_s = OWN_VGA;
    end else if (ldr_req && cpu_req) begin
      sel_s = rr_q ? OWN_LDR : OWN_CPU;
    end else if (cpu_req) begin
      sel_s = OWN_CPU;
    end else if (ldr_req) begin
      sel_s = OWN_LDR;
    end else begin
      sel_s = OWN_NONE;
    end
  end

  // Route the winner's payload; vga is read-only so its write enable is ignored.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    case (sel_s)
      OWN_VGA: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = vga_addr;
        sel_wdata_s = vga_wdata;
      end
      OWN_LDR: begin
        sel_we_s    = ldr_we;
        sel_addr_s  = ldr_addr;
        sel_wdata_s = ldr_wdata;
      end
      OWN_CPU: begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
      end
    endcase
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    done_d    = 3'b000;
    err_d     = 3'b000;
    start_d   = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    burst_d   = burst_q;
    case (state_q)
      S_INIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        if (!mem_ready) begin
          state_d = S_INIT;
        end else if (sel_s != OWN_NONE) begin
          state_d = S_ISSUE;
          owner_d = sel_s;
          start_d = 1'b1;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          burst_d = (sel_s == OWN_VGA);
          if (sel_s == OWN_CPU) begin
            rr_d = 1'b1;
          end else if (sel_s == OWN_LDR) begin
            rr_d = 1'b0;
          end else begin
            rr_d = rr_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (dram_data_ready) begin
          state_d = S_DONE;
          done_d  = owner_mask(owner_q);
          if (!we_q) begin
            rd_data_d = dram_data_out;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = owner_mask(owner_q);
          err_d   = owner_mask(owner_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        burst_d = 1'b0;
      end
      default: begin
        state_d = S_INIT;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        burst_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      owner_q   <= OWN_NONE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 3'b000;
      err_q     <= 3'b000;
      start_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      burst_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      burst_q   <= burst_d;
    end
  end

  assign vga_done      = done_q[0];
  assign ldr_done      = done_q[1];
  assign cpu_done      = done_q[2];
  assign vga_err       = err_q[0];
  assign ldr_err       = err_q[1];
  assign cpu_err       = err_q[2];
  assign rd_data       = rd_data_q;
  assign dram_start    = start_q;
  assign dram_write_en = we_q;
  assign dram_addr     = addr_q;
  assign dram_data_in  = wdata_q;
  assign dram_burst_en = burst_q;
  assign owner         = owner_q;

endmodule
